// File: rtl/matrix_mac_engine_if.sv
// Bundled control, operand-read and result-write signals of matrix_mac_engine.
// The engine connects through the slave modport; the requester and RAMs use the master side.
interface matrix_mac_engine_if #(
    parameter int DATA_W  = 16,
    parameter int C_W     = 32,
    parameter int MAX_DIM = 16
);
    localparam int IDX_W = $clog2(MAX_DIM);

    logic                      start;
    logic                      transpose_b;
    logic        [IDX_W:0]     dim_m;
    logic        [IDX_W:0]     dim_k;
    logic        [IDX_W:0]     dim_n;
    logic                      rd_en;
    logic        [2*IDX_W-1:0] a_addr;
    logic        [2*IDX_W-1:0] b_addr;
    logic signed [DATA_W-1:0]  a_rdata;
    logic signed [DATA_W-1:0]  b_rdata;
    logic                      c_we;
    logic        [2*IDX_W-1:0] c_addr;
    logic signed [C_W-1:0]     c_wdata;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport slave (
        input  start, transpose_b, dim_m, dim_k, dim_n, a_rdata, b_rdata,
        output rd_en, a_addr, b_addr, c_we, c_addr, c_wdata, busy, done, err
    );

    modport master (
        output start, transpose_b, dim_m, dim_k, dim_n, a_rdata, b_rdata,
        input  rd_en, a_addr, b_addr, c_we, c_addr, c_wdata, busy, done, err
    );
endinterface

// File: rtl/matrix_mac_engine.sv
// Matrix multiply-accumulate engine: C = A x B (or A x B^T) over synchronous operand RAM ports.
// Define MATMUL_SATURATE_EN to clamp results to the C_W range instead of truncating them.
module matrix_mac_engine #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int C_W     = 32,
    parameter int MAX_DIM = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    matrix_mac_engine_if.slave    bus
);
    localparam int IDX_W = $clog2(MAX_DIM);
    localparam logic [IDX_W:0]   DIM_MAX = (IDX_W+1)'(MAX_DIM);
    localparam logic [IDX_W:0]   DIM_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        [IDX_W:0]    r_dim_m;
    logic        [IDX_W:0]    r_dim_k;
    logic        [IDX_W:0]    r_dim_n;
    logic                     r_trans;
    logic                     r_err;
    logic        [IDX_W-1:0]  r_i;
    logic        [IDX_W-1:0]  r_j;
    logic        [IDX_W-1:0]  r_k;
    logic                     r_vld_p1;
    logic                     r_first_p1;
    logic signed [ACC_W-1:0]  r_acc;

    logic                     w_dims_bad;
    logic                     w_last_k;
    logic                     w_last_j;
    logic                     w_last_i;
    logic signed [2*DATA_W-1:0] w_a_ext_p1;
    logic signed [2*DATA_W-1:0] w_b_ext_p1;
    logic signed [2*DATA_W-1:0] w_prod_p1;
    logic signed [ACC_W-1:0]    w_prod_ext_p1;

`ifdef MATMUL_SATURATE_EN
    localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-C_W+1){1'b0}}, {(C_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_MIN = {{(ACC_W-C_W+1){1'b1}}, {(C_W-1){1'b0}}};
`endif

    // Narrow the accumulator to the result width written to the C RAM.
    function automatic logic signed [C_W-1:0] conv(input logic signed [ACC_W-1:0] acc);
`ifdef MATMUL_SATURATE_EN
        if (acc > C_MAX) begin
            conv = C_MAX[C_W-1:0];
        end else if (acc < C_MIN) begin
            conv = C_MIN[C_W-1:0];
        end else begin
            conv = acc[C_W-1:0];
        end
`else
        conv = acc[C_W-1:0];
`endif
    endfunction

    assign w_dims_bad = (r_dim_m == '0) || (r_dim_m > DIM_MAX) ||
                        (r_dim_k == '0) || (r_dim_k > DIM_MAX) ||
                        (r_dim_n == '0) || (r_dim_n > DIM_MAX);

    assign w_last_k = ({1'b0, r_k} == (r_dim_k - DIM_ONE));
    assign w_last_j = ({1'b0, r_j} == (r_dim_n - DIM_ONE));
    assign w_last_i = ({1'b0, r_i} == (r_dim_m - DIM_ONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_CHECK;
            S_CHECK: w_next = w_dims_bad ? S_FIN : S_RUN;
            S_RUN:   if (w_last_k) w_next = S_DRAIN;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: w_next = (w_last_i && w_last_j) ? S_FIN : S_RUN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operation registers and the i/j/k walk; k rewinds itself after the last inner read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dim_m <= '0;
            r_dim_k <= '0;
            r_dim_n <= '0;
            r_trans <= 1'b0;
            r_err   <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dim_m <= bus.dim_m;
                        r_dim_k <= bus.dim_k;
                        r_dim_n <= bus.dim_n;
                        r_trans <= bus.transpose_b;
                        r_err   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_dims_bad) begin
                        r_err <= 1'b1;
                    end else begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                S_RUN: begin
                    r_k <= w_last_k ? '0 : r_k + IDX_ONE;
                end
                S_WRITE: begin
                    if (w_last_j) begin
                        r_j <= '0;
                        r_i <= r_i + IDX_ONE;
                    end else begin
                        r_j <= r_j + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // p0 -> p1: read data returns one cycle after the RUN strobe
    assign w_a_ext_p1    = {{DATA_W{bus.a_rdata[DATA_W-1]}}, bus.a_rdata};
    assign w_b_ext_p1    = {{DATA_W{bus.b_rdata[DATA_W-1]}}, bus.b_rdata};
    assign w_prod_p1     = w_a_ext_p1 * w_b_ext_p1;
    assign w_prod_ext_p1 = {{(ACC_W-2*DATA_W){w_prod_p1[2*DATA_W-1]}}, w_prod_p1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_vld_p1   <= (r_state == S_RUN);
            r_first_p1 <= (r_k == '0);
            if (r_vld_p1) begin
                r_acc <= r_first_p1 ? w_prod_ext_p1 : r_acc + w_prod_ext_p1;
            end
        end
    end

    assign bus.rd_en   = (r_state == S_RUN);
    assign bus.a_addr  = {r_i, r_k};
    assign bus.b_addr  = r_trans ? {r_j, r_k} : {r_k, r_j};
    assign bus.c_we    = (r_state == S_WRITE);
    assign bus.c_addr  = {r_i, r_j};
    assign bus.c_wdata = conv(r_acc);
    assign bus.busy    = (r_state == S_CHECK) || (r_state == S_RUN) ||
                         (r_state == S_DRAIN) || (r_state == S_WRITE);
    assign bus.done    = (r_state == S_FIN);
    assign bus.err     = r_err;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Scoreboard bench for matrix_mac_engine with a 16-bit result width so that conv() is exercised.
// Expected C elements are queued at stimulus time and checked as c_we strobes appear.
module tb_matrix_mac_engine;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 40;
    localparam int C_W     = 16;
    localparam int MAX_DIM = 16;
    localparam int IDX_W   = 4;

    logic clk;
    logic reset_n;

    matrix_mac_engine_if #(.DATA_W(DATA_W), .C_W(C_W), .MAX_DIM(MAX_DIM)) bus ();

    matrix_mac_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .C_W(C_W), .MAX_DIM(MAX_DIM)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks;
    int failures;
    int rd_cnt;
    int we_cnt;
    int A [16][16];
    int B [16][16];
    logic signed [15:0] mem_a [256];
    logic signed [15:0] mem_b [256];
    logic [23:0] exp_q [$];
    logic [23:0] mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read operand RAMs
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_rdata <= mem_a[bus.a_addr];
            bus.b_rdata <= mem_b[bus.b_addr];
        end
    end

    always @(negedge clk) begin
        if (bus.rd_en === 1'b1) rd_cnt++;
        if (bus.c_we === 1'b1) begin
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL c_write unexpected addr=%h data=%h", bus.c_addr, bus.c_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.c_addr, bus.c_wdata} !== mon_e) begin
                    failures++;
                    $display("FAIL c_write got addr=%h data=%h expected addr=%h data=%h",
                             bus.c_addr, bus.c_wdata, mon_e[23:16], mon_e[15:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic signed [15:0] model_conv(input longint acc);
`ifdef MATMUL_SATURATE_EN
        if (acc > 64'sd32767) return 16'sh7fff;
        if (acc < -64'sd32768) return 16'sh8000;
        return acc[15:0];
`else
        return acc[15:0];
`endif
    endfunction

    task automatic prep_op(input int m, input int k, input int n, input bit tb);
        logic [7:0] ad;
        longint acc;
        if (m < 1 || m > MAX_DIM || k < 1 || k > MAX_DIM || n < 1 || n > MAX_DIM) return;
        for (int i = 0; i < m; i++)
            for (int kk = 0; kk < k; kk++) begin
                ad = {4'(i), 4'(kk)};
                mem_a[ad] = 16'(A[i][kk]);
            end
        for (int kk = 0; kk < k; kk++)
            for (int j = 0; j < n; j++) begin
                ad = tb ? {4'(j), 4'(kk)} : {4'(kk), 4'(j)};
                mem_b[ad] = 16'(B[kk][j]);
            end
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                acc = 0;
                for (int kk = 0; kk < k; kk++) acc += longint'(A[i][kk]) * longint'(B[kk][j]);
                exp_q.push_back({4'(i), 4'(j), model_conv(acc)});
            end
    endtask

    // Starts an operation, scrambles the inputs once it is accepted and waits for done.
    task automatic run_op(input int m, input int k, input int n, input bit tb,
                          input int poke_at, output int lat);
        prep_op(m, k, n, tb);
        rd_cnt = 0;
        we_cnt = 0;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.dim_m       = 5'(m);
        bus.dim_k       = 5'(k);
        bus.dim_n       = 5'(n);
        bus.transpose_b = tb;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            bus.start       = (c == poke_at);
            bus.dim_m       = 5'd1;
            bus.dim_k       = 5'd1;
            bus.dim_n       = 5'd1;
            bus.transpose_b = !tb;
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic set_t1();
        A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
        B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.transpose_b = 1'b0;
        bus.dim_m       = '0;
        bus.dim_k       = '0;
        bus.dim_n       = '0;
        bus.a_rdata     = '0;
        bus.b_rdata     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.rd_en, bus.c_we, bus.busy, bus.done, bus.err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b expected 00000",
                     {bus.rd_en, bus.c_we, bus.busy, bus.done, bus.err});
        end
        checks++;
        if ({bus.a_addr, bus.b_addr, bus.c_addr} !== 24'h0) begin
            failures++;
            $display("FAIL reset_addr got %h expected 0", {bus.a_addr, bus.b_addr, bus.c_addr});
        end
        checks++;
        if (bus.c_wdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_wdata got %h expected 0", bus.c_wdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dim_error();
        int lat;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) run_op(2, 0, 2, 1'b0, 0, lat);
            else        run_op(1, 1, MAX_DIM + 1, 1'b0, 0, lat);
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL err_latency case %0d got %0d expected 2", t, lat);
            end
            checks++;
            if (bus.err !== 1'b1) begin
                failures++;
                $display("FAIL err_flag case %0d got %b expected 1", t, bus.err);
            end
            checks++;
            if (rd_cnt !== 0 || we_cnt !== 0) begin
                failures++;
                $display("FAIL err_no_access case %0d got rd=%0d we=%0d expected 0/0", t, rd_cnt, we_cnt);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.err, bus.done} !== 2'b10) begin
            failures++;
            $display("FAIL err_sticky got err/done=%b expected 10", {bus.err, bus.done});
        end
    endtask

    task automatic test_basic(input string name, input int m, input int k, input int n,
                              input bit tb, input int poke_at);
        int lat;
        int exp_lat;
        exp_lat = m * n * (k + 2) + 2;
        run_op(m, k, n, tb, poke_at, lat);
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (exp_q.size() != 0 || we_cnt !== m * n) begin
            failures++;
            $display("FAIL %s_writes got %0d writes, %0d pending expected %0d, 0 pending",
                     name, we_cnt, exp_q.size(), m * n);
        end
        checks++;
        if (rd_cnt !== m * n * k) begin
            failures++;
            $display("FAIL %s_reads got %0d expected %0d", name, rd_cnt, m * n * k);
        end
        checks++;
        if ({bus.err, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL %s_status got err/busy=%b expected 00", name, {bus.err, bus.busy});
        end
        exp_q.delete();
    endtask

    task automatic test_saturate();
        for (int r = 0; r < 2; r++) begin
            A[0][r] = 32'h7fff;
            B[r][0] = 32'h7fff;
        end
        test_basic("sat", 1, 2, 1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                A[i][j] = $urandom_range(2000) - 1000;
                B[i][j] = $urandom_range(2000) - 1000;
            end
        test_basic("rand", 3, 4, 2, 1'b0, 0);
        test_basic("rand_t", 2, 3, 4, 1'b1, 0);
    endtask

    task automatic test_reset_mid();
        bit found;
        set_t1();
        prep_op(2, 2, 2, 1'b0);
        rd_cnt = 0;
        we_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dim_m = 5'd2;
        bus.dim_k = 5'd2;
        bus.dim_n = 5'd2;
        bus.transpose_b = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (we_cnt == 1 && bus.rd_en === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (found !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_reach got found=%b busy=%b expected 1/1", found, bus.busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.rd_en, bus.c_we, bus.busy, bus.done, bus.err} !== 5'b0 ||
            {bus.a_addr, bus.b_addr, bus.c_addr, bus.c_wdata} !== 40'h0) begin
            failures++;
            $display("FAIL midrun_reset got ctrl=%b bus=%h expected 0/0",
                     {bus.rd_en, bus.c_we, bus.busy, bus.done, bus.err},
                     {bus.a_addr, bus.b_addr, bus.c_addr, bus.c_wdata});
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (we_cnt !== 1) begin
            failures++;
            $display("FAIL midrun_no_write got %0d writes expected 1", we_cnt);
        end
    endtask

    task automatic test_back_to_back();
        set_t1();
        test_basic("b2b_a", 2, 2, 2, 1'b0, 0);
        test_basic("b2b_b", 2, 2, 2, 1'b1, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rd_cnt   = 0;
        we_cnt   = 0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        test_reset();
        test_dim_error();
        set_t1();
        test_basic("t1", 2, 2, 2, 1'b0, 0);
        test_basic("t2_transpose", 2, 2, 2, 1'b1, 0);
        A[0][0] = -1; A[0][1] = 2; A[0][2] = -3;
        B[0][0] = 4;  B[1][0] = -5; B[2][0] = 6;
        test_basic("t3", 1, 3, 1, 1'b0, 0);
        test_saturate();
        test_random();
        set_t1();
        test_basic("start_ignored", 2, 2, 2, 1'b0, 5);
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
